// File: rtl/tm_timer_bank.sv
// Wishbone slave with three 16-bit down-counting timers, each raising a sticky level interrupt.
// Define TM_TIMER_CAPTURE_EN to add per-timer capture registers fed by a shared cycle counter.
module tm_timer_bank #(
  parameter int WB_DWIDTH = 128,
  parameter int WB_SWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          i_wb_adr,
  input  logic [WB_SWIDTH-1:0] i_wb_sel,
  input  logic                 i_wb_we,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  output logic [2:0]           o_timer_int
);

  localparam logic [7:0] OFF_LOAD  = 8'h00;
  localparam logic [7:0] OFF_VALUE = 8'h04;
  localparam logic [7:0] OFF_CTRL  = 8'h08;
  localparam logic [7:0] OFF_CLR   = 8'h0C;
  localparam logic [7:0] OFF_STAT  = 8'h10;
  localparam logic [7:0] OFF_CAPT  = 8'h14;

  logic        rd_d1;
  logic        start_write;
  logic        start_read;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [31:0] rdata_q;

  logic [1:0]  tsel;
  logic [7:0]  off;
  logic        tvalid;
  logic [2:0]  wr_load;
  logic [2:0]  wr_ctrl;
  logic [2:0]  wr_clr;

  logic [7:0]  pre_q;
  logic [15:0] load_q  [3];
  logic [15:0] value_q [3];
  logic [1:0]  psc_q   [3];
  logic [2:0]  en_q;
  logic [2:0]  per_q;
  logic [2:0]  int_q;
  logic [2:0]  tick;
  logic [2:0]  expire;

  logic [2:0]  capt_en_rd;
  logic [31:0] capt_rd;

  // With we=0 the write term of ack is zero, so !ack reduces to !rd_d1.
  assign start_write = i_wb_stb & i_wb_we & ~rd_d1;
  assign start_read  = i_wb_stb & ~i_wb_we & ~rd_d1;
  assign o_wb_ack    = start_write | (i_wb_stb & rd_d1);
  assign o_wb_err    = 1'b0;
  assign o_timer_int = int_q;

  generate
    if (WB_DWIDTH == 128) begin : g_w128
      assign wdata    = i_wb_dat[{i_wb_adr[3:2], 5'd0} +: 32];
      assign o_wb_dat = {4{rdata_q}};
    end else begin : g_w32
      assign wdata    = i_wb_dat[31:0];
      assign o_wb_dat = rdata_q;
    end
  endgenerate

  assign tsel   = i_wb_adr[9:8];
  assign off    = i_wb_adr[7:0];
  assign tvalid = (i_wb_adr[15:10] == 6'd0) && (tsel != 2'd3);

  always_comb begin
    wr_load = '0;
    wr_ctrl = '0;
    wr_clr  = '0;
    for (int n = 0; n < 3; n++) begin
      if (start_write && tvalid && (tsel == 2'(n))) begin
        wr_load[n] = (off == OFF_LOAD);
        wr_ctrl[n] = (off == OFF_CTRL);
        wr_clr[n]  = (off == OFF_CLR);
      end
    end
  end

  always_comb begin
    tick   = '0;
    expire = '0;
    for (int n = 0; n < 3; n++) begin
      case (psc_q[n])
        2'd0:    tick[n] = 1'b1;
        2'd1:    tick[n] = (pre_q[3:0] == 4'hF);
        default: tick[n] = (pre_q == 8'hFF);
      endcase
      expire[n] = en_q[n] & tick[n] & (value_q[n] == 16'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= 8'd0;
      rd_d1   <= 1'b0;
      rdata_q <= 32'd0;
      en_q    <= 3'd0;
      per_q   <= 3'd0;
      int_q   <= 3'd0;
      for (int n = 0; n < 3; n++) begin
        load_q[n]  <= 16'd0;
        value_q[n] <= 16'd0;
        psc_q[n]   <= 2'd0;
      end
    end else begin
      pre_q <= pre_q + 8'd1;
      rd_d1 <= start_read;
      if (start_read) begin
        rdata_q <= rword;
      end
      for (int n = 0; n < 3; n++) begin
        // A LOAD write overrides both reload and decrement in the same cycle.
        if (wr_load[n]) begin
          load_q[n]  <= wdata[15:0];
          value_q[n] <= wdata[15:0];
        end else if (expire[n]) begin
          if (per_q[n]) begin
            value_q[n] <= load_q[n];
          end
        end else if (en_q[n] && tick[n]) begin
          value_q[n] <= value_q[n] - 16'd1;
        end

        if (wr_ctrl[n]) begin
          en_q[n]  <= wdata[7];
          per_q[n] <= wdata[6];
          psc_q[n] <= wdata[3:2];
        end else if (expire[n] && !per_q[n]) begin
          en_q[n] <= 1'b0;
        end

        // Expiry beats a simultaneous clear so no event is lost.
        if (expire[n]) begin
          int_q[n] <= 1'b1;
        end else if (wr_clr[n]) begin
          int_q[n] <= 1'b0;
        end
      end
    end
  end

`ifdef TM_TIMER_CAPTURE_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] capt_q [3];
  logic [2:0]  capt_en_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q <= 32'd0;
      capt_en_q <= 3'd0;
      for (int n = 0; n < 3; n++) begin
        capt_q[n] <= 32'd0;
      end
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      for (int n = 0; n < 3; n++) begin
        if (wr_ctrl[n]) begin
          capt_en_q[n] <= wdata[5];
        end
        if (expire[n] && capt_en_q[n]) begin
          capt_q[n] <= cyc_cnt_q;
        end
      end
    end
  end

  assign capt_en_rd = capt_en_q;
  assign capt_rd    = (tsel == 2'd3) ? 32'd0 : capt_q[tsel];
`else
  assign capt_en_rd = 3'd0;
  assign capt_rd    = 32'd0;
`endif

  always_comb begin
    rword = 32'd0;
    if (tvalid) begin
      case (off)
        OFF_LOAD:  rword = {16'd0, load_q[tsel]};
        OFF_VALUE: rword = {16'd0, value_q[tsel]};
        OFF_CTRL:  rword = {24'd0, en_q[tsel], per_q[tsel], capt_en_rd[tsel], 1'b0,
                            psc_q[tsel], 2'b00};
        OFF_STAT:  rword = {31'd0, int_q[tsel]};
        OFF_CAPT:  rword = capt_rd;
        default:   rword = 32'd0;
      endcase
    end
  end

  logic unused;
  assign unused = &{1'b0, i_wb_cyc, i_wb_sel, i_wb_adr[31:16], i_wb_adr[3:0], wdata[31:16],
                    wdata[4], wdata[1:0]};

endmodule

// File: tb/tb_tm_timer_bank.sv
// Directed bench for tm_timer_bank: reset state, periodic/one-shot timing, clear/load races, decode.
module tb_tm_timer_bank;
  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  adr;
  logic [15:0]  sel;
  logic         we;
  logic [127:0] dat;
  logic [127:0] rdat;
  logic         cyc;
  logic         stb;
  logic         ack;
  logic         err;
  logic [2:0]   tint;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_cyc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) ref_cyc <= 32'd0;
    else       ref_cyc <= ref_cyc + 32'd1;
  end

  tm_timer_bank dut (
    .clk        (clk),
    .reset      (reset),
    .i_wb_adr   (adr),
    .i_wb_sel   (sel),
    .i_wb_we    (we),
    .i_wb_dat   (dat),
    .o_wb_dat   (rdat),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .o_wb_ack   (ack),
    .o_wb_err   (err),
    .o_timer_int(tint)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [127:0] v;
    @(negedge clk);
    v = {4{32'hA5A5_5A5A}};
    v[a[3:2]*32 +: 32] = d;
    adr = a; dat = v; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    #1 chk("write_ack", ack, 1);
    @(posedge clk);
    #1 stb = 1'b0; we = 1'b0; cyc = 1'b0;
  endtask

  task automatic wb_read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    #1 chk({tag, "_ack_early"}, ack, 0);
    @(posedge clk);
    #1 chk({tag, "_ack"}, ack, 1);
    chk(tag, rdat, {4{exp}});
    @(posedge clk);
    #1 stb = 1'b0; cyc = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] c0;
    reset = 1'b1; adr = 32'd0; sel = '1; we = 1'b0; dat = '0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_int", tint, 3'b000);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    @(negedge clk) reset = 1'b0;

    for (int t = 0; t < 3; t++) begin
      for (int o = 0; o < 5; o++) begin
        wb_read_chk("rst_reg", (t << 8) | (o << 2), 32'd0);
      end
    end

    // T0 periodic /1, LOAD=3: expiry 4 edges after enable
    wb_write(32'h000, 32'd3);
    wb_write(32'h008, 32'hC0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1 chk("t0_before", tint, 3'b000);
    end
    @(posedge clk); #1 chk("t0_rise", tint, 3'b001);
    wb_write(32'h00C, 32'd0);
    chk("t0_clr", tint[0], 0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1 chk("t0_before2", tint[0], 0);
    end
    @(posedge clk); #1 chk("t0_rise2", tint[0], 1);
    wb_read_chk("t0_ctrl", 32'h008, 32'hC0);
    wb_write(32'h008, 32'h00);
    wb_write(32'h00C, 32'd0);
    chk("t0_off", tint[0], 0);

    // LOAD write while running overrides the pending decrement
    wb_write(32'h000, 32'd20);
    wb_write(32'h008, 32'hC0);
    repeat (13) @(posedge clk);
    wb_write(32'h000, 32'h0010);
    wb_read_chk("load_run_value", 32'h004, 32'h0010);
    wb_read_chk("load_run_load", 32'h000, 32'h0010);
    wb_write(32'h008, 32'h00);
    chk("load_run_int", tint[0], 0);

    // T1 one-shot /16, LOAD=2
    wb_write(32'h100, 32'd2);
    wb_write(32'h108, 32'h84);
    n = 0;
    while (!tint[1] && n < 80) begin
      @(posedge clk); #1 n++;
    end
    chk("t1_int", tint[1], 1);
    chk("t1_latency_in_window", (n >= 33 && n <= 63), 1);
    wb_read_chk("t1_ctrl_disabled", 32'h108, 32'h04);
    wb_read_chk("t1_value0", 32'h104, 32'd0);
    repeat (40) @(posedge clk);
    wb_read_chk("t1_value_hold", 32'h104, 32'd0);
    wb_read_chk("t1_stat", 32'h110, 32'd1);
    wb_read_chk("t1_clr_read", 32'h10C, 32'd0);
    wb_write(32'h10C, 32'd0);
    wb_read_chk("t1_stat_clr", 32'h110, 32'd0);

    // T2 LOAD=0 periodic /1 with CLR every cycle: expiry wins
    wb_write(32'h200, 32'd0);
    wb_write(32'h208, 32'hC0);
    @(negedge clk);
    adr = 32'h20C; dat = '0; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 chk("t2_int_held", tint[2], 1);
      chk("t2_wack", ack, 1);
    end
    stb = 1'b0; we = 1'b0; cyc = 1'b0;
    wb_write(32'h208, 32'h00);
    wb_write(32'h20C, 32'd0);
    chk("t2_cleared", tint, 3'b000);

    // Decode: timer 3, undefined offset, high address bits
    wb_write(32'h300, 32'h55);
    wb_read_chk("t3_load", 32'h300, 32'd0);
    wb_write(32'h018, 32'h55);
    wb_read_chk("undef_off", 32'h018, 32'd0);
    wb_write(32'h400, 32'h77);
    wb_read_chk("alias_load", 32'h000, 32'h0010);

`ifdef TM_TIMER_CAPTURE_EN
    wb_write(32'h000, 32'd1);
    wb_write(32'h008, 32'hE0);
    c0 = ref_cyc;
    repeat (2) @(posedge clk);
    wb_read_chk("capt", 32'h014, c0 + 32'd1);
    wb_read_chk("capt_ctrl", 32'h008, 32'hE0);
`else
    wb_write(32'h008, 32'hE0);
    c0 = 32'd0;
    wb_read_chk("capt_absent", 32'h014, c0);
    wb_read_chk("capt_ctrl", 32'h008, 32'hC0);
`endif
    wb_write(32'h008, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
